// File: rtl/spi_slave_fsm.sv
// SPI mode-0 slave transaction controller.
// Consumes conditioned CS/MOSI levels and SCLK edge pulses, decodes a
// 7-bit address plus R/W bit, then either shifts write data into the
// memory port or streams synchronous-read memory data out on MISO.
//
// state        | meaning
// IDLE         | waiting for chip select to go low
// GET_ADDR     | shifting in address bits and the R/W bit
// READ_ADDR    | address presented to memory, waiting for read latency
// READ_LOAD    | capturing memory read data into the transmit shifter
// READ_SHIFT   | driving read data on MISO, one bit per SCLK period
// WRITE_SHIFT  | shifting in write data bits
// WRITE_COMMIT | one-cycle memory write strobe
// DONE         | transfer complete, waiting for chip select to rise
module spi_slave_fsm #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_cond,
  input  logic                  sclk_posedge,
  input  logic                  sclk_negedge,
  input  logic                  mosi_cond,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  output logic                  miso_out,
  output logic                  miso_en
);

  // The receive shifter only needs to hold the bits preceding the final
  // one; the final bit is taken straight from mosi_cond when it arrives.
  localparam int RX_W = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    READ_ADDR    = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SHIFT   = 3'd4,
    WRITE_SHIFT  = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        count;
  logic [RX_W-1:0]   rx_sr;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic              addr_last;
  logic              data_last;
  logic              tx_advance;

  // Final address/R-W posedge and final data posedge of a transfer.
  assign addr_last  = sclk_posedge && (count == 4'(ADDR_WIDTH));
  assign data_last  = sclk_posedge && (count == 4'(DATA_WIDTH - 1));
  // A coincident posedge wins; the negedge right after R/W must not shift.
  assign tx_advance = sclk_negedge && !sclk_posedge && (count != 4'd0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; chip select high aborts every active phase but the commit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (!cs_cond) state_nxt = GET_ADDR;
      GET_ADDR: begin
        if (cs_cond)        state_nxt = IDLE;
        else if (addr_last) state_nxt = mosi_cond ? READ_ADDR : WRITE_SHIFT;
      end
      READ_ADDR:    state_nxt = cs_cond ? IDLE : READ_LOAD;
      READ_LOAD:    state_nxt = cs_cond ? IDLE : READ_SHIFT;
      READ_SHIFT: begin
        if (cs_cond)        state_nxt = IDLE;
        else if (data_last) state_nxt = DONE;
      end
      WRITE_SHIFT: begin
        if (cs_cond)        state_nxt = IDLE;
        else if (data_last) state_nxt = WRITE_COMMIT;
      end
      WRITE_COMMIT: state_nxt = DONE;
      DONE:         if (cs_cond) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Moore outputs: write strobe, MISO enable and the current transmit bit.
  always_comb begin
    mem_we   = 1'b0;
    miso_en  = 1'b0;
    miso_out = 1'b0;
    if (state == WRITE_COMMIT) mem_we = 1'b1;
    if (state == READ_SHIFT) begin
      miso_en  = 1'b1;
      miso_out = tx_sr[DATA_WIDTH-1];
    end
  end

  // Bit counter: cleared on every state change, counts SCLK rises while shifting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (state_nxt != state) begin
      count <= '0;
    end else if (sclk_posedge &&
                 (state == GET_ADDR || state == READ_SHIFT || state == WRITE_SHIFT)) begin
      count <= count + 4'd1;
    end
  end

  // Shift registers and memory port registers; aborted bits never reach the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sr    <= '0;
      tx_sr    <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (!cs_cond) begin
      case (state)
        GET_ADDR: begin
          if (sclk_posedge) rx_sr <= {rx_sr[RX_W-2:0], mosi_cond};
          if (addr_last)    mem_addr <= rx_sr[ADDR_WIDTH-1:0];
        end
        WRITE_SHIFT: begin
          if (sclk_posedge) rx_sr <= {rx_sr[RX_W-2:0], mosi_cond};
          if (data_last)    mem_din <= {rx_sr[DATA_WIDTH-2:0], mosi_cond};
        end
        READ_LOAD:  tx_sr <= mem_dout;
        READ_SHIFT: if (tx_advance) tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
        default: ;
      endcase
    end
  end

endmodule
